ram_block_copier: RTL and testbench

Bus-master engine that drives the 128x8 single-port data RAM to copy a block of bytes from a source address to a destination address. Sits beside the core datapath as the initiator side of the RAM port, muxed onto the RAM's `data`/`addr`/`ram_en` inputs by the top level while `busy` is high. It relies on the RAM's write-enable-gated synchronous write and same-cycle combinational read.

---
 rtl/ram_block_copier.sv | 105 ++++++++++
 tb/tb_ram_block_copier.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_block_copier.sv
// Block-copy bus master for a single-port RAM: alternates RD/WR cycles, one byte per two clocks.
// Optional RAM_COPY_CSUM_EN macro adds an 8-bit running sum of written bytes on csum_o.
module ram_block_copier #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [7:0]        len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_en_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic [7:0]        csum_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] dp_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] buf_q;
  logic              start_ok;

  // abort in IDLE wins over start, so the request is simply dropped
  assign start_ok = (state_q == S_IDLE) && start_i && !abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            sp_q    <= src_i;
            dp_q    <= dst_i;
            cnt_q   <= len_i;
            state_q <= (len_i != 8'd0) ? S_RD : S_DONE;
          end
        end
        S_RD: begin
          buf_q   <= ram_q_i;
          state_q <= abort_i ? S_IDLE : S_WR;
        end
        S_WR: begin
          // the RAM write lands on this edge even when abort is high
          sp_q  <= sp_q + 1'b1;
          dp_q  <= dp_q + 1'b1;
          cnt_q <= cnt_q - 8'd1;
          if (abort_i)             state_q <= S_IDLE;
          else if (cnt_q > 8'd1)   state_q <= S_RD;
          else                     state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign ram_en_o   = (state_q == S_WR);
  assign ram_addr_o = (state_q == S_RD) ? sp_q : (state_q == S_WR) ? dp_q : '0;
  assign ram_data_o = (state_q == S_WR) ? buf_q : '0;
  assign state_o    = state_q;

`ifdef RAM_COPY_CSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;

  assign csum_d = csum_q + 8'(buf_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (state_q == S_WR) begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = 8'd0;
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier: vector table of block copies plus hand-written
// busy-protection, abort, IDLE-abort and mid-copy reset sequences, against a behavioural RAM.
module tb_ram_block_copier;

`ifdef RAM_COPY_CSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] src = '0;
  logic [6:0] dst = '0;
  logic [7:0] len = '0;
  logic       busy, done, ram_en;
  logic [6:0] ram_addr;
  logic [7:0] ram_data, ram_q, csum;
  logic [1:0] state;

  logic [7:0] mem [128];
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int e0 = 0;
  int rel, end_k;

  typedef struct {
    logic [6:0]  s;
    logic [6:0]  d;
    logic [7:0]  l;
    logic [31:0] data;
    logic [31:0] expd;
    int          done_rel;
    int          en;
    logic [7:0]  cs;
  } vec_t;

  vec_t vecs [5];

  ram_block_copier dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .src_i      (src),
    .dst_i      (dst),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_data),
    .ram_en_o   (ram_en),
    .ram_q_i    (ram_q),
    .csum_o     (csum),
    .state_o    (state)
  );

  // clock / RAM model / monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_en) mem[ram_addr] <= ram_data;
  assign ram_q = mem[ram_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) en_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic prefill();
    for (int i = 0; i < 128; i++) mem[i] <= 8'(~i);
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] v);
    mem[a] <= v;
  endtask

  // Start a copy at edge E0, step cycle by cycle until busy drops.
  // abort_k / inj_k: cycle (relative to E0) in which abort or a stray start is raised.
  task automatic run_copy(input logic [6:0] s, input logic [6:0] d, input logic [7:0] l,
                          input int abort_k, input int inj_k,
                          output int rel_o, output int end_o);
    bit fin;
    en_cnt = 0; done_cnt = 0; done_cyc = -1; rel_o = -1; end_o = -1; fin = 1'b0;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    for (int k = 1; k <= 300 && !fin; k++) begin
      @(negedge clk);
      abort = (k == abort_k);
      start = (k == inj_k);
      if (k == inj_k) begin
        src = 7'h10; dst = 7'h20; len = 8'd2;
      end
      if (k == 1) check("busy_rise", int'(busy), 1);
      if (done) check("busy_in_done", int'(busy), 1);
      if (k > 1 && !busy) begin
        fin = 1'b1;
        end_o = k;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    if (!fin) check("timeout", 0, 1);
    if (done_cyc >= 0) rel_o = done_cyc - e0 + 1;
  endtask

  initial begin
    vecs[0] = '{s:7'h10, d:7'h40, l:8'd4, data:32'h44332211, expd:32'h44332211, done_rel:9, en:4, cs:8'hAA};
    vecs[1] = '{s:7'h7E, d:7'h7F, l:8'd3, data:32'h00C3B2A1, expd:32'h00A1A1A1, done_rel:7, en:3, cs:8'hE3};
    vecs[2] = '{s:7'h20, d:7'h30, l:8'd0, data:32'h0,        expd:32'h0,        done_rel:1, en:0, cs:8'h00};
    vecs[3] = '{s:7'h05, d:7'h60, l:8'd1, data:32'h7C,       expd:32'h7C,       done_rel:3, en:1, cs:8'h7C};
    vecs[4] = '{s:7'h50, d:7'h52, l:8'd2, data:32'h0201,     expd:32'h0201,     done_rel:5, en:2, cs:8'h03};

    // reset state
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_en", int'(ram_en), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_data", int'(ram_data), 0);
    check("rst_csum", int'(csum), 0);
    check("rst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven copies
    for (int i = 0; i < 5; i++) begin
      logic [31:0] dv, ev;
      @(negedge clk);
      prefill();
      dv = vecs[i].data;
      ev = vecs[i].expd;
      for (int j = 0; j < int'(vecs[i].l) && j < 4; j++) begin
        poke(7'(vecs[i].s + 7'(j)), dv[8*j +: 8]);
        exp_q.push_back(ev[8*j +: 8]);
      end
      run_copy(vecs[i].s, vecs[i].d, vecs[i].l, 0, 0, rel, end_k);
      check($sformatf("v%0d_done_cyc", i), rel, vecs[i].done_rel);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_en_cnt", i), en_cnt, vecs[i].en);
      check($sformatf("v%0d_idle_cyc", i), end_k, vecs[i].done_rel + 1);
      check($sformatf("v%0d_csum", i), int'(csum), CS_EN ? int'(vecs[i].cs) : 0);
      for (int j = 0; j < int'(vecs[i].l) && j < 4; j++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check($sformatf("v%0d_mem%0d", i, j), int'(mem[7'(vecs[i].d + 7'(j))]), int'(e));
      end
      if (vecs[i].l == 8'd0)
        check($sformatf("v%0d_mem_untouched", i), int'(mem[vecs[i].d]), int'(8'(~vecs[i].d)));
    end

    // stray start during a len=8 copy is ignored
    @(negedge clk);
    prefill();
    for (int j = 0; j < 8; j++) begin
      poke(7'(j), 8'(j * 3 + 1));
      exp_q.push_back(8'(j * 3 + 1));
    end
    run_copy(7'h00, 7'h70, 8'd8, 0, 3, rel, end_k);
    check("busyprot_done_cyc", rel, 17);
    check("busyprot_done_cnt", done_cnt, 1);
    check("busyprot_en_cnt", en_cnt, 8);
    check("busyprot_csum", int'(csum), CS_EN ? 8'h5C : 0);
    check("busyprot_mem20", int'(mem[7'h20]), 8'hDF);
    check("busyprot_mem21", int'(mem[7'h21]), 8'hDE);
    for (int j = 0; j < 8; j++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("busyprot_mem%0d", j), int'(mem[7'(7'h70 + 7'(j))]), int'(e));
    end

    // abort during the second WR of a len=4 copy
    @(negedge clk);
    prefill();
    poke(7'h10, 8'h11); poke(7'h11, 8'h22); poke(7'h12, 8'h33); poke(7'h13, 8'h44);
    run_copy(7'h10, 7'h40, 8'd4, 4, 0, rel, end_k);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_en_cnt", en_cnt, 2);
    check("abort_idle_cyc", end_k, 5);
    check("abort_mem40", int'(mem[7'h40]), 8'h11);
    check("abort_mem41", int'(mem[7'h41]), 8'h22);
    check("abort_mem42", int'(mem[7'h42]), 8'hBD);
    check("abort_csum", int'(csum), CS_EN ? 8'h33 : 0);

    // follow-up copy after abort
    @(negedge clk);
    poke(7'h05, 8'h7C);
    run_copy(7'h05, 7'h60, 8'd1, 0, 0, rel, end_k);
    check("post_abort_done_cyc", rel, 3);
    check("post_abort_mem60", int'(mem[7'h60]), 8'h7C);

    // abort in IDLE drops a simultaneous start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; src = 7'h00; dst = 7'h10; len = 8'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_state", int'(state), 0);

    // reset mid-copy clears outputs without a clock edge
    @(negedge clk);
    prefill();
    poke(7'h10, 8'h11); poke(7'h11, 8'h22); poke(7'h12, 8'h33); poke(7'h13, 8'h44);
    @(negedge clk);
    src = 7'h10; dst = 7'h40; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_en", int'(ram_en), 0);
    check("midrst_addr", int'(ram_addr), 0);
    check("midrst_data", int'(ram_data), 0);
    check("midrst_csum", int'(csum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    poke(7'h05, 8'h5A);
    run_copy(7'h05, 7'h61, 8'd1, 0, 0, rel, end_k);
    check("postrst_done_cyc", rel, 3);
    check("postrst_idle_cyc", end_k, 4);
    check("postrst_mem61", int'(mem[7'h61]), 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
